// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/FA_2HA.sv
// One-bit full adder built from two cascaded half adders.
module FA_2HA (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  assign ha0_sum   = a ^ b;
  assign ha0_carry = a & b;
  assign sum       = ha0_sum ^ cin;
  assign ha1_carry = ha0_sum & cin;
  assign carry     = ha0_carry | ha1_carry;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one bit per cycle, LSB first,
// and the registered result appears with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_carry;

  FA_2HA u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_bit = (state == ADD) && (cnt == CW'(WIDTH - 1));

  // NOTE: every output of an always_comb gets a default before the case so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = ADD;
      ADD:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ADD);
      done  <= (next_state == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        ADD: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= {fa_sum, res_sr[WIDTH-1:1]};
          carry_q <= fa_carry;
          cnt     <= cnt + 1'b1;
          // The final cell output is folded in directly so sum is complete on DONE entry.
          if (last_bit) begin
            sum  <= {fa_sum, res_sr[WIDTH-1:1]};
            cout <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard of expected {cout,sum} values,
// one task per scenario.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp;
  int n_err;
  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // lat is the cycle distance from the accept cycle to the done cycle.
  task automatic do_add(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic c_v,
                        output logic [W:0] got_res, output int lat, output int n_busy,
                        output bit got);
    a = a_v;
    b = b_v;
    cin = c_v;
    start = 1'b1;
    exp_q.push_back(model(a_v, b_v, c_v));
    @(posedge clk);
    #1;
    start = 1'b0;
    n_busy = 0;
    lat = 0;
    got = 1'b0;
    got_res = '0;
    for (int i = 1; i <= W + 4 && !got; i++) begin
      if (busy) n_busy++;
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        lat = i + 1;
        got_res = {cout, sum};
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #23;
    n_cmp++;
    if ({busy, done, cout, sum} !== '0) begin
      $display("FAIL reset_outputs: busy=%b done=%b cout=%b sum=%h, required all 0",
               busy, done, cout, sum);
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_and_compare(input string name, input logic [W-1:0] a_v,
                                 input logic [W-1:0] b_v, input logic c_v,
                                 input bit check_busy);
    logic [W:0] res;
    logic [W:0] exp_v;
    int lat;
    int nb;
    bit got;
    do_add(a_v, b_v, c_v, res, lat, nb, got);
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (!got) begin
      $display("FAIL %s_timeout: no done within %0d cycles", name, W + 4);
      n_err++;
    end else begin
      if (res !== exp_v) begin
        $display("FAIL %s_result: cout/sum=%h, required %h", name, res, exp_v);
        n_err++;
      end
      n_cmp++;
      if (lat !== W + 1) begin
        $display("FAIL %s_latency: %0d cycles, required %0d", name, lat, W + 1);
        n_err++;
      end
    end
    if (check_busy) begin
      n_cmp++;
      if (nb !== W) begin
        $display("FAIL %s_busy_cycles: %0d, required %0d", name, nb, W);
        n_err++;
      end
    end
  endtask

  // Start is driven on the same negedge the reset is released.
  task automatic test_basic();
    run_and_compare("basic_3c_42", 8'h3C, 8'h42, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    run_and_compare("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b1);
    run_and_compare("carry_5a_a5", 8'h5A, 8'hA5, 1'b1, 1'b1);
    run_and_compare("zero", 8'h00, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_ignore_start();
    int n_done;
    logic [W:0] res;
    logic [W:0] exp_v;
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    res = '0;
    for (int i = 0; i < 2 * W + 6; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        res = {cout, sum};
      end
    end
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (n_done !== 1) begin
      $display("FAIL ignore_done_count: %0d done pulses, required 1", n_done);
      n_err++;
    end
    n_cmp++;
    if (res !== exp_v) begin
      $display("FAIL ignore_result: cout/sum=%h, required %h", res, exp_v);
      n_err++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      $display("FAIL ignore_no_second_add: busy=%b, required 0", busy);
      n_err++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_add();
    int n_done;
    a = 8'h33;
    b = 8'h11;
    cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, cout, sum} !== '0) begin
      $display("FAIL midreset_outputs: busy=%b done=%b cout=%b sum=%h, required all 0",
               busy, done, cout, sum);
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) n_done++;
    end
    n_cmp++;
    if (n_done !== 0) begin
      $display("FAIL midreset_no_resume: %0d busy/done cycles after release, required 0",
               n_done);
      n_err++;
    end
    @(negedge clk);
    run_and_compare("after_reset_01_01", 8'h01, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n_done;
    int last_edge;
    logic [W:0] exp_v;
    a = 8'h07;
    b = 8'h09;
    cin = 1'b0;
    start = 1'b1;
    repeat (3) exp_q.push_back(model(8'h07, 8'h09, 1'b0));
    n_done = 0;
    last_edge = 0;
    for (int e = 1; e <= 3 * W + 5; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          $display("FAIL b2b_extra_done: done at edge %0d, required no more", e);
          n_err++;
        end else begin
          exp_v = exp_q.pop_front();
          n_cmp++;
          if ({cout, sum} !== exp_v) begin
            $display("FAIL b2b_result: cout/sum=%h, required %h", {cout, sum}, exp_v);
            n_err++;
          end
        end
        if (last_edge != 0) begin
          n_cmp++;
          if (e - last_edge !== W + 2) begin
            $display("FAIL b2b_interval: %0d cycles, required %0d", e - last_edge, W + 2);
            n_err++;
          end
        end
        last_edge = e;
      end
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (n_done !== 3) begin
      $display("FAIL b2b_done_count: %0d, required 3", n_done);
      n_err++;
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_and_compare("random", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_ignore_start();
    test_reset_mid_add();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
